// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
//   master (host) : drives start, a, b; observes c, r, dz, busy, done
//   slave (divider): observes start, a, b; drives c, r, dz, busy, done
//   start  request a division (accepted only while busy=0)
//   a, b   dividend / divisor, sampled on the accepting edge
//   c, r   quotient / remainder of the last completed operation
//   dz     divide-by-zero flag of the last completed operation
//   busy   division in progress
//   done   one-cycle strobe when c, r, dz become valid
interface seq_divider_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] r;
    logic             dz;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  c, r, dz, busy, done
    );

    modport slave (
        input  start, a, b,
        output c, r, dz, busy, done
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    seq_divider_if slave modport (start/a/b in, c/r/dz/busy/done out)
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, one shift-subtract step per edge
// DONE  | one-cycle result strobe; a new start is accepted here too
module seq_divider #(
    parameter int WIDTH = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] b_q;
    // Partial remainder. It is always below the divisor after a step, so
    // its MSB would be permanently zero and is not stored.
    logic [WIDTH-1:0] p_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] r_q;
    logic             dz_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   p_shift_d;
    logic             p_ge_d;
    logic [WIDTH-1:0] p_diff_d;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] q_d;
    logic             accept_d;

    always_comb begin
        p_shift_d = {p_q, q_q[WIDTH-1]};
        p_ge_d    = (p_shift_d >= {1'b0, b_q});
        // When the subtraction is taken the true difference is below the
        // divisor, so truncating to WIDTH bits loses nothing.
        p_diff_d  = p_shift_d[WIDTH-1:0] - b_q;
        p_d       = p_ge_d ? p_diff_d : p_shift_d[WIDTH-1:0];
        q_d       = {q_q[WIDTH-2:0], p_ge_d};
        accept_d  = bus.start && !busy_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (accept_d) begin
                        if (bus.b != '0) begin
                            q_q     <= bus.a;
                            b_q     <= bus.b;
                            p_q     <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end else begin
                            c_q     <= '1;
                            r_q     <= bus.a;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                CALC: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        c_q     <= q_d;
                        r_q     <= p_d;
                        dz_q    <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.c    = c_q;
    assign bus.r    = r_q;
    assign bus.dz   = dz_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=24).
module tb_seq_divider;
    localparam int W = 24;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start=1 for exactly one edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        step();
        bus.start = 1'b0;
        bus.a     = 'x;
        bus.b     = 'x;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({bus.busy, bus.done, bus.dz, bus.c, bus.r} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b dz=%b c=%h r=%h expected all 0",
                     bus.busy, bus.done, bus.dz, bus.c, bus.r);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        int bad_busy;
        bad_busy = 0;
        issue(24'h000064, 24'h000007);
        // busy for 24 cycles, done never before the 24th edge
        for (int i = 0; i < W; i++) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad_busy++;
            step();
        end
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL basic_busy_window bad_cycles=%0d expected 0", bad_busy);
        end
        checks++;
        if ({bus.done, bus.busy, bus.dz} !== 3'b100) begin
            errors++;
            $display("FAIL basic_done done=%b busy=%b dz=%b expected 1 0 0", bus.done, bus.busy, bus.dz);
        end
        checks++;
        if (bus.c !== 24'h00000E || bus.r !== 24'h000002) begin
            errors++;
            $display("FAIL basic_result c=%h r=%h expected 00000e 000002", bus.c, bus.r);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.c !== 24'h00000E || bus.r !== 24'h000002) begin
            errors++;
            $display("FAIL basic_hold done=%b c=%h r=%h expected 0 00000e 000002", bus.done, bus.c, bus.r);
        end
    endtask

    task automatic test_values();
        issue(24'hFFFFFF, 24'h000001);
        repeat (W) step();
        checks++;
        if (bus.done !== 1'b1 || bus.c !== 24'hFFFFFF || bus.r !== 24'h000000) begin
            errors++;
            $display("FAIL max_by_one done=%b c=%h r=%h expected 1 ffffff 000000", bus.done, bus.c, bus.r);
        end
        step();
        issue(24'h000005, 24'h000009);
        repeat (W) step();
        checks++;
        if (bus.done !== 1'b1 || bus.c !== 24'h000000 || bus.r !== 24'h000005) begin
            errors++;
            $display("FAIL small_dividend done=%b c=%h r=%h expected 1 000000 000005", bus.done, bus.c, bus.r);
        end
    endtask

    // Called while the previous operation is in its DONE cycle.
    task automatic test_back_to_back();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_precondition done=%b expected 1", bus.done);
        end
        issue(24'h001000, 24'h000010);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept busy=%b done=%b expected 1 0", bus.busy, bus.done);
        end
        repeat (W - 1) step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early_done done=%b expected 0 at edge 23", bus.done);
        end
        step();
        checks++;
        if (bus.done !== 1'b1 || bus.c !== 24'h000100 || bus.r !== 24'h000000 || bus.dz !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result done=%b c=%h r=%h dz=%b expected 1 000100 000000 0",
                     bus.done, bus.c, bus.r, bus.dz);
        end
    endtask

    // Also called in a DONE cycle: done stays high for a second cycle.
    task automatic test_div_zero();
        issue(24'h487468, 24'h000000);
        checks++;
        if (bus.done !== 1'b1 || bus.dz !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL dz_flags done=%b dz=%b busy=%b expected 1 1 0", bus.done, bus.dz, bus.busy);
        end
        checks++;
        if (bus.c !== 24'hFFFFFF || bus.r !== 24'h487468) begin
            errors++;
            $display("FAIL dz_result c=%h r=%h expected ffffff 487468", bus.c, bus.r);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.dz !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL dz_hold done=%b dz=%b busy=%b expected 0 1 0", bus.done, bus.dz, bus.busy);
        end
    endtask

    // 4 * 0x203547 + 0x03C318 = 0x849834
    task automatic test_ignore_start();
        issue(24'h849834, 24'h203547);
        repeat (4) step();
        issue(24'h000001, 24'h000001);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy busy=%b done=%b expected 1 0", bus.busy, bus.done);
        end
        repeat (W - 6) step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_early_done done=%b expected 0 at edge 23", bus.done);
        end
        step();
        checks++;
        if (bus.done !== 1'b1 || bus.c !== 24'h000004 || bus.r !== 24'h03C318 || bus.dz !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result done=%b c=%h r=%h dz=%b expected 1 000004 03c318 0",
                     bus.done, bus.c, bus.r, bus.dz);
        end
        step();
    endtask

    task automatic test_reset_abort();
        int saw_done;
        saw_done = 0;
        issue(24'h849834, 24'h203547);
        repeat (9) step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({bus.busy, bus.done, bus.dz, bus.c, bus.r} !== '0) begin
            errors++;
            $display("FAIL abort_clear busy=%b done=%b dz=%b c=%h r=%h expected all 0",
                     bus.busy, bus.done, bus.dz, bus.c, bus.r);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            step();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done++;
        end
        checks++;
        if (saw_done != 0) begin
            errors++;
            $display("FAIL abort_no_done active_cycles=%0d expected 0", saw_done);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1;
        test_reset();
        test_basic();
        test_values();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
